// File: rtl/riscv_32i_defs_pkg.sv
// Shared rv32i definitions: register-file address/data types plus the
// write-arbiter state encoding and staged-write record.
package riscv_32i_defs_pkg;

   localparam int XLEN      = 32;
   localparam int RF_DEPTH  = 32;
   localparam int RF_ADDR_W = $clog2(RF_DEPTH);

   typedef logic [RF_ADDR_W-1:0] rf_addr_t;
   typedef logic [XLEN-1:0]      word_t;

   localparam rf_addr_t X0           = '0;
   localparam rf_addr_t RF_LAST_ADDR = rf_addr_t'(RF_DEPTH - 1);

   typedef enum logic {
      ARB_INIT,
      ARB_RUN
   } arb_state_t;

   // One register-file write as presented to the reg_file port.
   typedef struct packed {
      logic     en;
      rf_addr_t addr;
      word_t    data;
   } rf_wr_t;

endpackage

// File: rtl/rf_wr_arbiter_rr_arb2.sv
// Two-way round-robin grant with its priority pointer.  The grant is
// combinational from the valids; the pointer flips to the other side after
// every grant and holds when nothing is granted.
module rr_arb2 #(
   parameter bit RESET_PRIO = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_en,
   input  logic [1:0] i_valid,
   output logic [1:0] o_grant
);

   logic       r_ptr;
   logic [1:0] w_grant;

   // Grant a lone requester; on contention grant the pointer side.
   always_comb begin
      // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
      w_grant = 2'b00;
      if (i_en) begin
         case (i_valid)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = r_ptr ? 2'b10 : 2'b01;
            default: w_grant = 2'b00;
         endcase
      end
   end

   // Pointer moves to the requester that was not just served.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
      if (rst)
         r_ptr <= RESET_PRIO;
      else if (|w_grant)
         r_ptr <= w_grant[0];
   end

   assign o_grant = w_grant;

endmodule

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port owner for rv32i.  Arbitrates two writeback
// requesters round-robin and registers the winning write one cycle before
// it reaches the reg_file.  Build macro RF_INIT_CLEAR_EN enables the
// post-reset walk that writes INIT_VALUE to x1..x31; without it the INIT
// state is never entered and busy is tied low.
module rf_wr_arbiter
   import riscv_32i_defs_pkg::*;
#(
   parameter bit    RR_RESET_PRIO = 1'b0,
   parameter word_t INIT_VALUE    = 32'h0000_0000
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     req0_valid,
   output logic     req0_ready,
   input  rf_addr_t req0_addr,
   input  word_t    req0_data,
   input  logic     req1_valid,
   output logic     req1_ready,
   input  rf_addr_t req1_addr,
   input  word_t    req1_data,
   output logic     rf_wr_en,
   output rf_addr_t rf_wr_reg,
   output word_t    rf_wr_data,
   output logic     busy
);

`ifdef RF_INIT_CLEAR_EN
   localparam arb_state_t RESET_STATE = ARB_INIT;
`else
   localparam arb_state_t RESET_STATE = ARB_RUN;
`endif

   arb_state_t r_state;
   arb_state_t w_state_nxt;
   rf_addr_t   r_init_addr;
   logic       w_run;
   logic [1:0] w_grant;
   logic       w_stage_load;
   rf_wr_t     w_stage;
   rf_wr_t     r_wr;

   assign w_run = (r_state == ARB_RUN);

   rr_arb2 #(
      .RESET_PRIO (RR_RESET_PRIO)
   ) u_rr_arb2 (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_run),
      .i_valid ({req1_valid, req0_valid}),
      .o_grant (w_grant)
   );

   // Clear-walk address: starts at x1 after every reset, advances while in INIT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_init_addr <= rf_addr_t'(1);
      else if (r_state == ARB_INIT)
         r_init_addr <= r_init_addr + rf_addr_t'(1);
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= RESET_STATE;
      else
         r_state <= w_state_nxt;
   end

   // Next state and the write to stage this cycle (walk entry or granted request).
   always_comb begin
      w_state_nxt  = r_state;
      w_stage_load = 1'b0;
      w_stage      = '0;
      case (r_state)
         ARB_INIT: begin
            w_stage_load = 1'b1;
            w_stage.en   = 1'b1;
            w_stage.addr = r_init_addr;
            w_stage.data = INIT_VALUE;
            if (r_init_addr == RF_LAST_ADDR)
               w_state_nxt = ARB_RUN;
         end
         ARB_RUN: begin
            if (|w_grant) begin
               w_stage_load = 1'b1;
               w_stage.addr = w_grant[0] ? req0_addr : req1_addr;
               w_stage.data = w_grant[0] ? req0_data : req1_data;
               // x0 writes are accepted but never committed.
               w_stage.en   = (w_stage.addr != X0);
            end
         end
         default: w_state_nxt = RESET_STATE;
      endcase
   end

   // Write stage: enable is a pulse per staged write; address/data hold otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr <= '0;
      end else begin
         r_wr.en <= w_stage.en;
         if (w_stage_load) begin
            r_wr.addr <= w_stage.addr;
            r_wr.data <= w_stage.data;
         end
      end
   end

   assign req0_ready = w_grant[0];
   assign req1_ready = w_grant[1];
   assign rf_wr_en   = r_wr.en;
   assign rf_wr_reg  = r_wr.addr;
   assign rf_wr_data = r_wr.data;

`ifdef RF_INIT_CLEAR_EN
   assign busy = (r_state == ARB_INIT);
`else
   assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed bench for rf_wr_arbiter: expected writes are queued when a step
// is driven and compared when the write stage presents them; a behavioural
// register file captures committed writes for readback checks.
module tb_rf_wr_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [4:0]  req0_addr,  req1_addr;
   logic [31:0] req0_data,  req1_data;
   logic        rf_wr_en;
   logic [4:0]  rf_wr_reg;
   logic [31:0] rf_wr_data;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        chk;
      logic        en;
      logic [4:0]  rg;
      logic [31:0] dt;
   } exp_t;

   exp_t sb[$];

   logic [31:0] rf_mem [32] = '{default: '0};

   always #5 clk = ~clk;

   rf_wr_arbiter #(
      .RR_RESET_PRIO (1'b0),
      .INIT_VALUE    (32'h0000_0000)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_addr  (req0_addr),
      .req0_data  (req0_data),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_addr  (req1_addr),
      .req1_data  (req1_data),
      .rf_wr_en   (rf_wr_en),
      .rf_wr_reg  (rf_wr_reg),
      .rf_wr_data (rf_wr_data),
      .busy       (busy)
   );

   // Register file that commits whatever the arbiter enables, x0 included,
   // so a stray x0 write shows up in readback.
   always @(posedge clk)
      if (rf_wr_en)
         rf_mem[rf_wr_reg] <= rf_wr_data;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One cycle of stimulus: drive, check readies, queue the expected write,
   // then compare the staged write one edge later.
   task automatic step(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic e0, input logic e1, input string tag);
      exp_t it;
      req0_valid = v0; req0_addr = a0; req0_data = d0;
      req1_valid = v1; req1_addr = a1; req1_data = d1;
      #1;
      check({tag, ".ready0"}, {31'b0, req0_ready}, {31'b0, e0});
      check({tag, ".ready1"}, {31'b0, req1_ready}, {31'b0, e1});
      it.chk = e0 | e1;
      it.rg  = e0 ? a0 : a1;
      it.dt  = e0 ? d0 : d1;
      it.en  = it.chk && (it.rg != 5'd0);
      sb.push_back(it);
      @(negedge clk);
      it = sb.pop_front();
      check({tag, ".wr_en"}, {31'b0, rf_wr_en}, {31'b0, it.en});
      if (it.chk) begin
         check({tag, ".wr_reg"}, {27'b0, rf_wr_reg}, {27'b0, it.rg});
         check({tag, ".wr_data"}, rf_wr_data, it.dt);
      end
   endtask

   task automatic idle(input string tag);
      step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, tag);
   endtask

   // Bounded wait for the clear walk to finish (no-op without the walk).
   task automatic wait_init();
`ifdef RF_INIT_CLEAR_EN
      for (int k = 0; k < 40 && busy; k++)
         @(negedge clk);
      check("init_done", {31'b0, busy}, 32'd0);
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
      req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
      #1;
      check("rst.wr_en",   {31'b0, rf_wr_en}, 32'd0);
      check("rst.wr_reg",  {27'b0, rf_wr_reg}, 32'd0);
      check("rst.wr_data", rf_wr_data, 32'd0);
      check("rst.ready0",  {31'b0, req0_ready}, 32'd0);
      check("rst.ready1",  {31'b0, req1_ready}, 32'd0);
`ifdef RF_INIT_CLEAR_EN
      check("rst.busy",    {31'b0, busy}, 32'd1);
`else
      check("rst.busy",    {31'b0, busy}, 32'd0);
`endif
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

`ifdef RF_INIT_CLEAR_EN
      // Walk x1..x31 with a requester knocking the whole time.
      req0_valid = 1'b1; req0_addr = 5'd6; req0_data = 32'h5555_5555;
      #1;
      check("init.busy0",   {31'b0, busy}, 32'd1);
      check("init.ready0",  {31'b0, req0_ready}, 32'd0);
      for (int i = 1; i <= 31; i++) begin
         @(negedge clk);
         if (i == 31) req0_valid = 1'b0;
         #1;
         check("init.wr_en",   {31'b0, rf_wr_en}, 32'd1);
         check("init.wr_reg",  {27'b0, rf_wr_reg}, i);
         check("init.wr_data", rf_wr_data, 32'h0);
         check("init.busy",    {31'b0, busy}, (i < 31) ? 32'd1 : 32'd0);
         if (i < 31)
            check("init.ready", {31'b0, req0_ready}, 32'd0);
      end
      idle("init_tail");
      for (int r = 0; r < 32; r++)
         check("init.readback", rf_mem[r], 32'h0);
`endif

      // Continuous contention, pointer starts at requester 0.
      step(1'b1, 5'd1, 32'h1111_1111, 1'b1, 5'd2, 32'h2222_2222, 1'b1, 1'b0, "rr0");
      step(1'b1, 5'd1, 32'h1111_1111, 1'b1, 5'd2, 32'h2222_2222, 1'b0, 1'b1, "rr1");
      step(1'b1, 5'd1, 32'h1111_1111, 1'b1, 5'd2, 32'h2222_2222, 1'b1, 1'b0, "rr2");
      step(1'b1, 5'd1, 32'h1111_1111, 1'b1, 5'd2, 32'h2222_2222, 1'b0, 1'b1, "rr3");
      idle("idle0");

      // Single write, then contention with the pointer on requester 1.
      step(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, "single");
      step(1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd4, 32'h0000_0044, 1'b0, 1'b1, "ptr1");
      check("readback.x5", rf_mem[5], 32'hDEAD_BEEF);

      // x0 write is accepted but not enabled.
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0000_1234, 1'b0, 1'b1, "x0");

      // Same-address pair: later grant wins.
      step(1'b1, 5'd7, 32'h0000_000A, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, "x7a");
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h0000_000B, 1'b0, 1'b1, "x7b");
      idle("idle1");
      check("readback.x0", rf_mem[0], 32'h0);
      check("readback.x4", rf_mem[4], 32'h0000_0044);
      check("readback.x7", rf_mem[7], 32'h0000_000B);

      // Grant, then reset while the write is staged.
      step(1'b1, 5'd9, 32'h0000_0099, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, "pre_rst");
      req0_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("midrst.wr_en", {31'b0, rf_wr_en}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("midrst.x9", rf_mem[9], 32'h0);
      wait_init();

      // Pointer is back at requester 0 (would be 1 without the reset).
      step(1'b1, 5'd10, 32'h0000_00AA, 1'b1, 5'd11, 32'h0000_00BB, 1'b1, 1'b0, "post_rst");
      idle("idle2");
      check("readback.x10", rf_mem[10], 32'h0000_00AA);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
